// File: rtl/sgd_pkg.sv
// Shared types and defaults for the SGD sequencer and its serial deserialiser.
// Holds the FSM state encoding, the default word length and the lane index helper.
package sgd_pkg;

    localparam int LENGTH_DEF       = 16;
    localparam int MAX_FEATURES_DEF = 15;

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Words of a point arrive highest lane first, so word k of a point lands in lane (nw-1)-k.
    function automatic logic [3:0] lane_of(input logic [3:0] nw_m1, input logic [3:0] word_idx);
        return nw_m1 - word_idx;
    endfunction

endpackage

// File: rtl/sgd_ser_deser.sv
// Bit-serial to row deserialiser: LSB-first words, highest lane first, into one wide row.
// Latency: row_vld/row_dat update on the edge that samples the last bit of lane 0.
// No backpressure: one bit accepted every enabled cycle; row_vld is a 1-cycle pulse.
module sgd_ser_deser
    import sgd_pkg::*;
#(
    parameter int LENGTH     = LENGTH_DEF,
    parameter int DATA_WIDTH = LENGTH_DEF * (MAX_FEATURES_DEF + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  s,
    input  logic [3:0]            nw_m1,
    output logic                  row_done,
    output logic                  row_vld,
    output logic [DATA_WIDTH-1:0] row_dat
);

    localparam int BW = $clog2(LENGTH);

    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [3:0]            word_cnt_q, word_cnt_d;
    logic [LENGTH-1:0]     sh_q, sh_d;
    logic [DATA_WIDTH-1:0] row_q, row_d;
    logic                  row_vld_q, row_vld_d;
    logic [LENGTH-1:0]     word;
    logic [3:0]            lane;

    // Shift in one bit per cycle; on a word boundary drop it into its lane, on the last lane flag the row.
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        sh_d       = sh_q;
        row_d      = row_q;
        row_vld_d  = 1'b0;
        row_done   = 1'b0;
        word       = {s, sh_q[LENGTH-1:1]};
        lane       = lane_of(nw_m1, word_cnt_q);
        if (en) begin
            sh_d = word;
            if (bit_cnt_q == BW'(LENGTH - 1)) begin
                bit_cnt_d = '0;
                row_d[LENGTH*int'(lane) +: LENGTH] = word;
                if (word_cnt_q == nw_m1) begin
                    word_cnt_d = '0;
                    row_done   = 1'b1;
                    row_vld_d  = 1'b1;
                end else begin
                    word_cnt_d = word_cnt_q + 4'd1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + BW'(1);
            end
        end
    end

    // Assembler state; reset drops any partial row and clears unused lanes.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            sh_q       <= '0;
            row_q      <= '0;
            row_vld_q  <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            sh_q       <= sh_d;
            row_q      <= row_d;
            row_vld_q  <= row_vld_d;
        end
    end

    assign row_vld = row_vld_q;
    assign row_dat = row_q;

endmodule

// File: rtl/sgd_sequencer.sv
// SGD accelerator controller: loads serial training rows into memory, then runs epoch x point updates.
// Latency: row write 1 cycle after its last bit; minimum 3 cycles per update pass (issue/start/wait).
// Backpressure: waits indefinitely in WAIT for the datapath's upd_done pulse; serial input never stalls.
module sgd_sequencer
    import sgd_pkg::*;
#(
    parameter int ADDR_WIDTH   = 12,
    parameter int MAX_FEATURES = MAX_FEATURES_DEF,
    parameter int LENGTH       = LENGTH_DEF,
    parameter int DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  S,
    input  logic [3:0]            feat,
    input  logic [7:0]            epoch,
    input  logic [3:0]            learn_rate,
    input  logic [ADDR_WIDTH-1:0] data_points,
    input  logic                  upd_done,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic                  upd_start,
    output logic                  upd_last,
    output logic [3:0]            lr_shift,
    output logic [3:0]            feat_q,
    output logic [7:0]            epoch_cnt,
    output logic                  busy,
    output logic                  SGD_DONE
);

    state_t                state_q, state_d;
    logic [3:0]            feat_d;
    logic [7:0]            epoch_cfg_q, epoch_cfg_d;
    logic [3:0]            lr_shift_q, lr_shift_d;
    logic [ADDR_WIDTH-1:0] dp_cfg_q, dp_cfg_d;
    logic [ADDR_WIDTH-1:0] dp_cnt_q, dp_cnt_d;
    logic [7:0]            epoch_cnt_q, epoch_cnt_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic                  row_done;
    logic                  deser_en;
    logic                  at_last_dp;
    logic                  at_last_ep;

    assign at_last_dp = (dp_cnt_q == dp_cfg_q - ADDR_WIDTH'(1));
    assign at_last_ep = (epoch_cnt_q == epoch_cfg_q - 8'd1);
    // With zero points there is nothing to load, so the deserialiser never runs.
    assign deser_en   = (state_q == ST_LOAD) && (dp_cfg_q != '0);

    sgd_ser_deser #(
        .LENGTH     (LENGTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_deser (
        .clk      (CLK),
        .rst      (RST),
        .en       (deser_en),
        .s        (S),
        .nw_m1    (feat_q),
        .row_done (row_done),
        .row_vld  (mem_we),
        .row_dat  (mem_wdata)
    );

    // Configuration follows the inputs while in reset and freezes once running; feat is clamped.
    always_comb begin
        feat_d      = feat_q;
        epoch_cfg_d = epoch_cfg_q;
        lr_shift_d  = lr_shift_q;
        dp_cfg_d    = dp_cfg_q;
        if (RST) begin
            feat_d      = (int'(feat) > MAX_FEATURES) ? 4'(MAX_FEATURES) : feat;
            epoch_cfg_d = epoch;
            lr_shift_d  = learn_rate;
            dp_cfg_d    = data_points;
        end
    end

    // Configuration registers (no reset value of their own: reset is the capture window).
    always_ff @(posedge CLK) begin
        feat_q      <= feat_d;
        epoch_cfg_q <= epoch_cfg_d;
        lr_shift_q  <= lr_shift_d;
        dp_cfg_q    <= dp_cfg_d;
    end

    // Next state: load all rows, then issue/start/wait per row until the final epoch wraps.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: begin
                if (dp_cfg_q == '0) begin
                    state_d = ST_DONE;
                end else if (row_done && at_last_dp) begin
                    state_d = (epoch_cfg_q == 8'd0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_START;
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (upd_done) begin
                    state_d = (at_last_dp && at_last_ep) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_LOAD;
        endcase
    end

    // Run counters: dp_cnt indexes rows for both writing and reading; epoch_cnt counts full passes.
    always_comb begin
        dp_cnt_d    = dp_cnt_q;
        epoch_cnt_d = epoch_cnt_q;
        waddr_d     = waddr_q;
        if (state_q == ST_LOAD && row_done) begin
            waddr_d  = dp_cnt_q;
            dp_cnt_d = at_last_dp ? '0 : dp_cnt_q + ADDR_WIDTH'(1);
        end else if (state_q == ST_WAIT && upd_done) begin
            if (at_last_dp) begin
                dp_cnt_d    = '0;
                epoch_cnt_d = epoch_cnt_q + 8'd1;
            end else begin
                dp_cnt_d = dp_cnt_q + ADDR_WIDTH'(1);
            end
        end
        // Present the read address during ISSUE so the sync RAM row is ready in START.
        raddr_d = (state_d == ST_ISSUE) ? dp_cnt_d : raddr_q;
    end

    // State register and run counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_LOAD;
            dp_cnt_q    <= '0;
            epoch_cnt_q <= '0;
            waddr_q     <= '0;
            raddr_q     <= '0;
        end else begin
            state_q     <= state_d;
            dp_cnt_q    <= dp_cnt_d;
            epoch_cnt_q <= epoch_cnt_d;
            waddr_q     <= waddr_d;
            raddr_q     <= raddr_d;
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        upd_start = (state_q == ST_START);
        upd_last  = (state_q == ST_START) && at_last_dp;
        busy      = (state_q != ST_DONE);
        SGD_DONE  = (state_q == ST_DONE);
    end

    assign mem_waddr = waddr_q;
    assign mem_raddr = raddr_q;
    assign lr_shift  = lr_shift_q;
    assign epoch_cnt = epoch_cnt_q;

endmodule

// File: tb/tb_sgd_sequencer.sv
module tb_sgd_sequencer;
    import sgd_pkg::*;

    localparam int AW = 12;
    localparam int DW = 256;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          S = 1'b0;
    logic [3:0]    feat = 4'd0;
    logic [7:0]    epoch = 8'd0;
    logic [3:0]    learn_rate = 4'd0;
    logic [AW-1:0] data_points = '0;
    logic          upd_done = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [AW-1:0] mem_raddr;
    logic          upd_start;
    logic          upd_last;
    logic [3:0]    lr_shift;
    logic [3:0]    feat_q;
    logic [7:0]    epoch_cnt;
    logic          busy;
    logic          SGD_DONE;

    int n_checks = 0;
    int n_err = 0;

    `define CHK(tag, obs, exp) begin \
        n_checks++; \
        assert ((obs) === (exp)) else begin \
            n_err++; \
            $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); \
        end \
    end

    sgd_sequencer #(
        .ADDR_WIDTH   (AW),
        .MAX_FEATURES (15),
        .LENGTH       (16),
        .DATA_WIDTH   (DW)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .S           (S),
        .feat        (feat),
        .epoch       (epoch),
        .learn_rate  (learn_rate),
        .data_points (data_points),
        .upd_done    (upd_done),
        .mem_we      (mem_we),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .mem_raddr   (mem_raddr),
        .upd_start   (upd_start),
        .upd_last    (upd_last),
        .lr_shift    (lr_shift),
        .feat_q      (feat_q),
        .epoch_cnt   (epoch_cnt),
        .busy        (busy),
        .SGD_DONE    (SGD_DONE)
    );

    always #5 CLK = ~CLK;

    // Rising edges since reset release: edge 1 samples the first serial bit.
    int edge_cnt = 0;
    always @(posedge CLK) begin
        if (RST) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    // Event logs, appended only here.
    int            wr_addr_q[$];
    int            wr_edge_q[$];
    logic [DW-1:0] wr_data_q[$];
    int            st_raddr_q[$];
    int            st_last_q[$];
    always @(negedge CLK) begin
        if (mem_we) begin
            wr_addr_q.push_back(int'(mem_waddr));
            wr_edge_q.push_back(edge_cnt);
            wr_data_q.push_back(mem_wdata);
        end
        if (upd_start) begin
            st_raddr_q.push_back(int'(mem_raddr));
            st_last_q.push_back(int'(upd_last));
        end
    end

    // Training words: sel 0 is an arbitrary per point/lane pattern, sel 1 the fixed y/x1/x2 set.
    function automatic logic [15:0] wv(input int sel, input int p, input int l);
        if (sel == 0) return 16'((p * 499 + l * 177 + 42307) % 65536);
        case (l)
            0:       return 16'h0001;
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [DW-1:0] exp_row(input int sel, input int nf, input int p);
        logic [DW-1:0] r;
        r = '0;
        for (int l = 0; l <= nf; l++) r[16*l +: 16] = wv(sel, p, l);
        return r;
    endfunction

    task automatic do_reset(input int f, input int e, input int lr, input int dp);
        @(negedge CLK);
        RST = 1'b1;
        S = 1'b0;
        feat = 4'(f);
        epoch = 8'(e);
        learn_rate = 4'(lr);
        data_points = AW'(dp);
        repeat (3) @(negedge CLK);
    endtask

    // Releases reset with the first bit; stop_at >= 0 re-asserts reset in place of that bit.
    task automatic load(input int nf, input int npts, input int sel, input int stop_at);
        int idx;
        logic [15:0] w;
        idx = 0;
        for (int p = 0; p < npts; p++) begin
            for (int l = nf; l >= 0; l--) begin
                w = wv(sel, p, l);
                for (int b = 0; b < 16; b++) begin
                    @(negedge CLK);
                    if (idx == stop_at) begin
                        RST = 1'b1;
                        return;
                    end
                    RST = 1'b0;
                    S = w[b];
                    idx++;
                end
            end
        end
    endtask

    // Answers each upd_start with a 1-cycle upd_done dly cycles later, until SGD_DONE or budget.
    task automatic serve(input int dly, input int budget);
        int cnt;
        cnt = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (SGD_DONE) break;
            upd_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) upd_done = 1'b1;
            end
            if (upd_start) cnt = dly;
        end
        upd_done = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (SGD_DONE) break;
        end
    endtask

    initial begin
        int wb, sb, bad, nlast;
        logic [DW-1:0] r2;

        // ---------------- reset state + test 1: feat=11, dp=5, epoch=100
        do_reset(11, 100, 5, 5);
        `CHK("rst_mem_we", mem_we, 1'b0)
        `CHK("rst_upd_start", upd_start, 1'b0)
        `CHK("rst_upd_last", upd_last, 1'b0)
        `CHK("rst_done", SGD_DONE, 1'b0)
        `CHK("rst_busy", busy, 1'b1)
        `CHK("rst_epoch_cnt", epoch_cnt, 8'd0)
        `CHK("rst_raddr", mem_raddr, 12'd0)
        `CHK("rst_waddr", mem_waddr, 12'd0)
        `CHK("rst_wdata", mem_wdata, 256'd0)
        `CHK("rst_lr_shift", lr_shift, 4'd5)
        `CHK("rst_feat_q", feat_q, 4'd11)
        `CHK("rst_state", dut.state_q, ST_LOAD)
        wb = wr_addr_q.size();
        sb = st_raddr_q.size();
        load(11, 5, 0, -1);
        serve(4, 5000);
        `CHK("t1_nwrites", wr_addr_q.size() - wb, 5)
        for (int k = 0; k < 5; k++) begin
            `CHK("t1_waddr", wr_addr_q[wb+k], k)
            `CHK("t1_wedge", wr_edge_q[wb+k], 192 * (k + 1))
            `CHK("t1_wdata", wr_data_q[wb+k], exp_row(0, 11, k))
        end
        `CHK("t1_nstarts", st_raddr_q.size() - sb, 500)
        bad = 0;
        nlast = 0;
        for (int i = 0; i < st_raddr_q.size() - sb; i++) begin
            if (st_raddr_q[sb+i] != i % 5) bad++;
            if (st_last_q[sb+i] != int'(i % 5 == 4)) bad++;
            nlast += st_last_q[sb+i];
        end
        `CHK("t1_seq_bad", bad, 0)
        `CHK("t1_nlast", nlast, 100)
        `CHK("t1_done", SGD_DONE, 1'b1)
        `CHK("t1_busy", busy, 1'b0)
        `CHK("t1_epoch_cnt", epoch_cnt, 8'd100)

        // ---------------- test 2: feat=2, dp=3, epoch=1, fixed words
        do_reset(2, 1, 0, 3);
        wb = wr_addr_q.size();
        sb = st_raddr_q.size();
        load(2, 3, 1, -1);
        serve(1, 200);
        r2 = '0;
        r2[47:0] = 48'hFFFF_8000_0001;
        `CHK("t2_nwrites", wr_addr_q.size() - wb, 3)
        for (int k = 0; k < 3; k++) begin
            `CHK("t2_wdata", wr_data_q[wb+k], r2)
            `CHK("t2_wedge", wr_edge_q[wb+k], 48 * (k + 1))
        end
        `CHK("t2_nstarts", st_raddr_q.size() - sb, 3)
        `CHK("t2_raddr0", st_raddr_q[sb], 0)
        `CHK("t2_raddr1", st_raddr_q[sb+1], 1)
        `CHK("t2_raddr2", st_raddr_q[sb+2], 2)
        `CHK("t2_last1", st_last_q[sb+1], 0)
        `CHK("t2_last2", st_last_q[sb+2], 1)
        `CHK("t2_done", SGD_DONE, 1'b1)
        `CHK("t2_epoch_cnt", epoch_cnt, 8'd1)

        // ---------------- test 3a: data_points=0
        do_reset(3, 5, 0, 0);
        wb = wr_addr_q.size();
        sb = st_raddr_q.size();
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        `CHK("t3a_done_first", SGD_DONE, 1'b1)
        `CHK("t3a_busy", busy, 1'b0)
        repeat (10) @(negedge CLK);
        `CHK("t3a_nwrites", wr_addr_q.size() - wb, 0)
        `CHK("t3a_nstarts", st_raddr_q.size() - sb, 0)
        `CHK("t3a_epoch_cnt", epoch_cnt, 8'd0)

        // ---------------- test 3b: epoch=0, dp=2
        do_reset(1, 0, 0, 2);
        wb = wr_addr_q.size();
        sb = st_raddr_q.size();
        load(1, 2, 0, -1);
        @(negedge CLK);
        `CHK("t3b_we_last", mem_we, 1'b1)
        `CHK("t3b_waddr_last", mem_waddr, 12'd1)
        `CHK("t3b_done", SGD_DONE, 1'b1)
        repeat (10) @(negedge CLK);
        `CHK("t3b_nwrites", wr_addr_q.size() - wb, 2)
        `CHK("t3b_wdata1", wr_data_q[wb+1], exp_row(0, 1, 1))
        `CHK("t3b_nstarts", st_raddr_q.size() - sb, 0)

        // ---------------- test 4: feat=15, all 16 lanes
        do_reset(15, 1, 0, 1);
        `CHK("t4_feat_q", feat_q, 4'd15)
        wb = wr_addr_q.size();
        sb = st_raddr_q.size();
        load(15, 1, 0, -1);
        serve(2, 100);
        `CHK("t4_nwrites", wr_addr_q.size() - wb, 1)
        `CHK("t4_wedge", wr_edge_q[wb], 256)
        `CHK("t4_wdata", wr_data_q[wb], exp_row(0, 15, 0))
        `CHK("t4_nstarts", st_raddr_q.size() - sb, 1)
        `CHK("t4_last", st_last_q[sb], 1)
        `CHK("t4_done", SGD_DONE, 1'b1)

        // ---------------- test 5: reset mid-load, reload, reset during WAIT
        do_reset(11, 2, 0, 3);
        wb = wr_addr_q.size();
        load(11, 3, 0, 192 + 100);
        @(negedge CLK);
        `CHK("t5_abort_state", dut.state_q, ST_LOAD)
        `CHK("t5_abort_we", mem_we, 1'b0)
        `CHK("t5_abort_wdata", mem_wdata, 256'd0)
        repeat (2) @(negedge CLK);
        `CHK("t5_partial_nwrites", wr_addr_q.size() - wb, 1)
        wb = wr_addr_q.size();
        sb = st_raddr_q.size();
        load(11, 3, 0, -1);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (upd_start) break;
        end
        `CHK("t5_reload_nwrites", wr_addr_q.size() - wb, 3)
        `CHK("t5_reload_addr0", wr_addr_q[wb], 0)
        `CHK("t5_reload_edge0", wr_edge_q[wb], 192)
        `CHK("t5_reload_data0", wr_data_q[wb], exp_row(0, 11, 0))
        @(negedge CLK);
        `CHK("t5_in_wait", dut.state_q, ST_WAIT)
        RST = 1'b1;
        @(negedge CLK);
        `CHK("t5_wait_abort_state", dut.state_q, ST_LOAD)
        `CHK("t5_wait_abort_busy", busy, 1'b1)
        repeat (10) @(negedge CLK);
        `CHK("t5_wait_abort_nstarts", st_raddr_q.size() - sb, 1)

        // ---------------- test 6: upd_done held high throughout
        upd_done = 1'b1;
        do_reset(0, 2, 0, 2);
        wb = wr_addr_q.size();
        sb = st_raddr_q.size();
        load(0, 2, 0, -1);
        wait_done(100);
        `CHK("t6_nwrites", wr_addr_q.size() - wb, 2)
        `CHK("t6_waddr0", wr_addr_q[wb], 0)
        `CHK("t6_waddr1", wr_addr_q[wb+1], 1)
        `CHK("t6_wdata1", wr_data_q[wb+1], exp_row(0, 0, 1))
        `CHK("t6_nstarts", st_raddr_q.size() - sb, 4)
        bad = 0;
        for (int i = 0; i < st_raddr_q.size() - sb; i++) begin
            if (st_raddr_q[sb+i] != i % 2) bad++;
            if (st_last_q[sb+i] != i % 2) bad++;
        end
        `CHK("t6_seq_bad", bad, 0)
        `CHK("t6_epoch_cnt", epoch_cnt, 8'd2)
        repeat (5) @(negedge CLK);
        `CHK("t6_hold_epoch_cnt", epoch_cnt, 8'd2)
        `CHK("t6_hold_done", SGD_DONE, 1'b1)
        `CHK("t6_hold_nstarts", st_raddr_q.size() - sb, 4)
        upd_done = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
